// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame/divisor widths.
// Kept separate so the receiver can reuse the same constants.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DIV_WIDTH  = 16;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable bit-period down-counter; bit_end_o is high on the last clock of each bit.
// The owner reloads it with (clocks per bit - 1) on every bit start.
module uart_baud_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         bit_end_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from a first-word-fall-through FIFO: start, LSB-first data,
// optional parity, one or two stop bits. Frame configuration is latched at pop time.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop2,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    // A divisor of zero behaves like one clock per bit.
    function automatic logic [DIV_WIDTH-1:0] div_m1(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DIV_WIDTH-1:0]  div_m1_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  stop_idx_q;

    logic                  bit_end;
    logic                  cnt_load;
    logic [DIV_WIDTH-1:0]  cnt_load_val;

    assign fifo_rd_en   = !rst && (state_q == TX_IDLE) && !fifo_empty;
    assign busy         = !rst && ((state_q != TX_IDLE) || fifo_rd_en);
    assign tx_done      = !rst && (state_q == TX_STOP) && bit_end && (stop_idx_q == stop2_q);

    // The pop cycle loads straight from the input since the latched copy is not valid yet.
    assign cnt_load     = fifo_rd_en || ((state_q != TX_IDLE) && bit_end);
    assign cnt_load_val = fifo_rd_en ? div_m1(baud_div) : div_m1_q;

    uart_baud_cnt #(
        .W(DIV_WIDTH)
    ) u_baud_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .bit_end_o  (bit_end)
    );

    always_comb begin
        txd = 1'b1;
        case (state_q)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = shift_q[0];
            TX_PARITY: txd = par_bit_q;
            default:   txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            div_m1_q   <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (fifo_rd_en) begin
                        shift_q    <= fifo_dout;
                        idx_q      <= '0;
                        div_m1_q   <= div_m1(baud_div);
                        par_en_q   <= parity_en;
                        par_bit_q  <= (^fifo_dout) ^ parity_odd;
                        stop2_q    <= stop2;
                        stop_idx_q <= 1'b0;
                        state_q    <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end)
                        state_q <= TX_DATA;
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(DATA_WIDTH - 1))
                            state_q <= par_en_q ? TX_PARITY : TX_STOP;
                    end
                end
                TX_PARITY: begin
                    if (bit_end)
                        state_q <= TX_STOP;
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (stop_idx_q == stop2_q)
                            state_q <= TX_IDLE;
                        else
                            stop_idx_q <= 1'b1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a queue models the FWFT FIFO, every cycle's outputs are
// logged, and each scenario checks the log against hand-written frames.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rd_en, txd, busy, tx_done;

    uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fq[$];
    logic lg_txd  [0:255];
    logic lg_done [0:255];
    logic lg_busy [0:255];
    logic lg_rd   [0:255];
    int   lg_n = 0;

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
        fifo_dout  = fq[0];
    endtask

    // Log one cycle's outputs, cross the edge, then retire a popped entry.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            logic       rd;
            logic [7:0] tmp;
            #1;
            if (lg_n < 256) begin
                lg_txd[lg_n]  = txd;
                lg_done[lg_n] = tx_done;
                lg_busy[lg_n] = busy;
                lg_rd[lg_n]   = fifo_rd_en;
            end
            rd = fifo_rd_en;
            lg_n++;
            @(posedge clk);
            #1;
            if (rd && fq.size() > 0) tmp = fq.pop_front();
            fifo_empty = (fq.size() == 0);
            fifo_dout  = fifo_empty ? 8'h00 : fq[0];
        end
    endtask

    // kind 0: fifo_rd_en, 1: tx_done
    function automatic int first_one(input int kind, input int from);
        for (int i = (from < 0 ? 0 : from); i < lg_n && i < 256; i++)
            if ((kind == 0 ? lg_rd[i] : lg_done[i]) === 1'b1) return i;
        return -1;
    endfunction

    // kind 0: pops, 1: tx_done pulses, 2: busy cycles, 3: txd-low cycles
    function automatic int count_one(input int kind);
        int c = 0;
        for (int i = 0; i < lg_n && i < 256; i++) begin
            case (kind)
                0: c += (lg_rd[i] === 1'b1) ? 1 : 0;
                1: c += (lg_done[i] === 1'b1) ? 1 : 0;
                2: c += (lg_busy[i] === 1'b1) ? 1 : 0;
                default: c += (lg_txd[i] === 1'b0) ? 1 : 0;
            endcase
        end
        return c;
    endfunction

    // Level of txd over [s, s+len); 2 if it moved inside the window, 3 if out of range.
    function automatic int bit_val(input int s, input int len);
        if (s < 0 || s + len > lg_n || s + len > 256) return 3;
        for (int i = s + 1; i < s + len; i++)
            if (lg_txd[i] !== lg_txd[s]) return 2;
        return (lg_txd[s] === 1'b1) ? 1 : 0;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        push(8'h3C);
        lg_n = 0;
        run(3);
        n_tests++; if (lg_rd[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rd0: got %b expected 0", lg_rd[0]); end
        n_tests++; if (lg_rd[2] !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", lg_rd[2]); end
        n_tests++; if (lg_txd[2] !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", lg_txd[2]); end
        n_tests++; if (lg_busy[2] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", lg_busy[2]); end
        n_tests++; if (lg_done[2] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", lg_done[2]); end
        fq.delete();
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        rst = 1'b0;
        run(2);
    endtask

    task automatic test_8n1;
        logic [9:0] exp = 10'b1101001010;
        int p, d, v;
        baud_div = 16'd4;
        lg_n = 0;
        push(8'hA5);
        run(45);
        p = first_one(0, 0);
        d = first_one(1, 0);
        n_tests++; if (p !== 0) begin n_fail++; $display("FAIL 8n1_pop_idx: got %0d expected 0", p); end
        n_tests++; if (count_one(0) !== 1) begin n_fail++; $display("FAIL 8n1_pops: got %0d expected 1", count_one(0)); end
        n_tests++; if (lg_busy[0] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_pop: got %b expected 1", lg_busy[0]); end
        for (int b = 0; b < 10; b++) begin
            v = bit_val(p + 1 + b * 4, 4);
            n_tests++; if (v !== int'(exp[b])) begin n_fail++; $display("FAIL 8n1_bit%0d: got %0d expected %0d", b, v, exp[b]); end
        end
        n_tests++; if (d !== 40) begin n_fail++; $display("FAIL 8n1_done_idx: got %0d expected 40", d); end
        n_tests++; if (count_one(1) !== 1) begin n_fail++; $display("FAIL 8n1_done_cnt: got %0d expected 1", count_one(1)); end
        n_tests++; if (lg_busy[40] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_last: got %b expected 1", lg_busy[40]); end
        n_tests++; if (lg_busy[41] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_after: got %b expected 0", lg_busy[41]); end
        n_tests++; if (lg_txd[41] !== 1'b1) begin n_fail++; $display("FAIL 8n1_txd_idle: got %b expected 1", lg_txd[41]); end
    endtask

    task automatic test_parity;
        logic [10:0] exp_even = 11'b11000001110;
        int p, d, v;
        baud_div = 16'd3;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        lg_n = 0;
        push(8'h07);
        run(36);
        p = first_one(0, 0);
        d = first_one(1, 0);
        for (int b = 0; b < 11; b++) begin
            v = bit_val(p + 1 + b * 3, 3);
            n_tests++; if (v !== int'(exp_even[b])) begin n_fail++; $display("FAIL par_even_bit%0d: got %0d expected %0d", b, v, exp_even[b]); end
        end
        n_tests++; if (d - p !== 33) begin n_fail++; $display("FAIL par_even_len: got %0d expected 33", d - p); end
        parity_odd = 1'b1;
        lg_n = 0;
        push(8'h07);
        run(36);
        p = first_one(0, 0);
        d = first_one(1, 0);
        v = bit_val(p + 1 + 9 * 3, 3);
        n_tests++; if (v !== 0) begin n_fail++; $display("FAIL par_odd_bit: got %0d expected 0", v); end
        v = bit_val(p + 1 + 10 * 3, 3);
        n_tests++; if (v !== 1) begin n_fail++; $display("FAIL par_odd_stop: got %0d expected 1", v); end
        n_tests++; if (d - p !== 33) begin n_fail++; $display("FAIL par_odd_len: got %0d expected 33", d - p); end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [10:0] exp1 = 11'b11010101010;
        logic [10:0] exp2 = 11'b11000000000;
        int p1, p2, d1, d2, v;
        baud_div = 16'd2;
        stop2 = 1'b1;
        lg_n = 0;
        push(8'h55);
        push(8'h00);
        run(50);
        p1 = first_one(0, 0);
        d1 = first_one(1, 0);
        p2 = first_one(0, p1 + 1);
        d2 = first_one(1, d1 + 1);
        n_tests++; if (d1 - p1 !== 22) begin n_fail++; $display("FAIL b2b_len1: got %0d expected 22", d1 - p1); end
        n_tests++; if (p2 - d1 !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 1", p2 - d1); end
        n_tests++; if (d2 - p2 !== 22) begin n_fail++; $display("FAIL b2b_len2: got %0d expected 22", d2 - p2); end
        n_tests++; if (count_one(0) !== 2) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 2", count_one(0)); end
        v = bit_val(p1 + 19, 4);
        n_tests++; if (v !== 1) begin n_fail++; $display("FAIL b2b_stop_hi: got %0d expected 1", v); end
        for (int b = 0; b < 11; b++) begin
            v = bit_val(p1 + 1 + b * 2, 2);
            n_tests++; if (v !== int'(exp1[b])) begin n_fail++; $display("FAIL b2b_f1_bit%0d: got %0d expected %0d", b, v, exp1[b]); end
            v = bit_val(p2 + 1 + b * 2, 2);
            n_tests++; if (v !== int'(exp2[b])) begin n_fail++; $display("FAIL b2b_f2_bit%0d: got %0d expected %0d", b, v, exp2[b]); end
        end
        stop2 = 1'b0;
    endtask

    task automatic test_div0;
        logic [9:0] exp = 10'b1100000010;
        int p, d, v;
        baud_div = 16'd0;
        lg_n = 0;
        push(8'h81);
        run(14);
        p = first_one(0, 0);
        d = first_one(1, 0);
        for (int b = 0; b < 10; b++) begin
            v = bit_val(p + 1 + b, 1);
            n_tests++; if (v !== int'(exp[b])) begin n_fail++; $display("FAIL div0_bit%0d: got %0d expected %0d", b, v, exp[b]); end
        end
        n_tests++; if (d - p !== 10) begin n_fail++; $display("FAIL div0_len: got %0d expected 10", d - p); end
    endtask

    task automatic test_div_change;
        logic [9:0] exp1 = 10'b1000011110;
        logic [9:0] exp2 = 10'b1111100000;
        int p, d, v;
        baud_div = 16'd4;
        lg_n = 0;
        push(8'h0F);
        run(1);
        baud_div = 16'd8;
        stop2 = 1'b1;
        parity_en = 1'b1;
        run(44);
        p = first_one(0, 0);
        d = first_one(1, 0);
        n_tests++; if (d - p !== 40) begin n_fail++; $display("FAIL chg_len1: got %0d expected 40", d - p); end
        for (int b = 0; b < 10; b++) begin
            v = bit_val(p + 1 + b * 4, 4);
            n_tests++; if (v !== int'(exp1[b])) begin n_fail++; $display("FAIL chg_f1_bit%0d: got %0d expected %0d", b, v, exp1[b]); end
        end
        stop2 = 1'b0;
        parity_en = 1'b0;
        lg_n = 0;
        push(8'hF0);
        run(84);
        p = first_one(0, 0);
        d = first_one(1, 0);
        n_tests++; if (d - p !== 80) begin n_fail++; $display("FAIL chg_len2: got %0d expected 80", d - p); end
        for (int b = 0; b < 10; b++) begin
            v = bit_val(p + 1 + b * 8, 8);
            n_tests++; if (v !== int'(exp2[b])) begin n_fail++; $display("FAIL chg_f2_bit%0d: got %0d expected %0d", b, v, exp2[b]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] exp = 10'b1001111000;
        int p2, d, v;
        baud_div = 16'd4;
        lg_n = 0;
        push(8'hA5);
        push(8'h3C);
        run(10);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(50);
        n_tests++; if (lg_txd[11] !== 1'b1) begin n_fail++; $display("FAIL rmid_txd: got %b expected 1", lg_txd[11]); end
        n_tests++; if (lg_busy[11] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", lg_busy[11]); end
        p2 = first_one(0, 1);
        d = first_one(1, 0);
        n_tests++; if (p2 !== 12) begin n_fail++; $display("FAIL rmid_pop2: got %0d expected 12", p2); end
        n_tests++; if (d !== 52) begin n_fail++; $display("FAIL rmid_done: got %0d expected 52", d); end
        n_tests++; if (count_one(1) !== 1) begin n_fail++; $display("FAIL rmid_done_cnt: got %0d expected 1", count_one(1)); end
        for (int b = 0; b < 10; b++) begin
            v = bit_val(p2 + 1 + b * 4, 4);
            n_tests++; if (v !== int'(exp[b])) begin n_fail++; $display("FAIL rmid_bit%0d: got %0d expected %0d", b, v, exp[b]); end
        end
    endtask

    task automatic test_idle;
        lg_n = 0;
        run(100);
        n_tests++; if (count_one(0) !== 0) begin n_fail++; $display("FAIL idle_pops: got %0d expected 0", count_one(0)); end
        n_tests++; if (count_one(3) !== 0) begin n_fail++; $display("FAIL idle_txd_low: got %0d expected 0", count_one(3)); end
        n_tests++; if (count_one(2) !== 0) begin n_fail++; $display("FAIL idle_busy: got %0d expected 0", count_one(2)); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_div0();
        test_div_change();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame (LSB first).
REQ-002 Parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 baud_div  input  DIV_WIDTH  clocks per bit period; value 0 is treated as 1.
REQ-006 parity_en  input  1  1 = append parity bit after data.
REQ-007 parity_odd  input  1  1 = odd parity, 0 = even (ignored when parity_en=0).
REQ-008 stop2  input  1  1 = two stop bits, 0 = one.
REQ-009 fifo_empty  input  1  empty flag of the upstream FWFT TX FIFO.
REQ-010 fifo_dout  input  DATA_WIDTH  FWFT head-of-FIFO data, valid whenever fifo_empty=0.
REQ-011 fifo_rd_en  output  1  one-cycle pop strobe to the TX FIFO.
REQ-012 txd  output  1  serial line, idle high.
REQ-013 busy  output  1  high from pop cycle until the last stop bit completes.
REQ-014 tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Function
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP; the state register alone determines txd.
REQ-016 IDLE: txd=1; when fifo_empty=0, assert fifo_rd_en combinationally for exactly that cycle, capture fifo_dout into the shift register, and latch baud_div, parity_en, parity_odd and stop2; go to START.
REQ-017 The FSM never asserts fifo_rd_en outside IDLE and never while fifo_empty=1.
REQ-018 Latency: txd falls on the first clk edge after the fifo_rd_en cycle.
REQ-019 Bit counter reloads with latched divisor-1 on every bit start, decrements each clk, and the bit ends when it reaches 0; each bit lasts exactly max(baud_div,1) clocks.
REQ-020 START: txd=0 for one bit period, then DATA.
REQ-021 DATA: txd=shift_reg[0], shift right each bit end; after DATA_WIDTH bits go to PARITY if parity_en is latched high, otherwise to STOP.
REQ-022 PARITY: txd = XOR of the captured data bits XOR parity_odd, for one bit period.
REQ-023 STOP: txd=1 for one bit period (two if stop2 latched); tx_done=1 on its final cycle.
REQ-024 Back-to-back: on the cycle after tx_done, FSM is in IDLE; if fifo_empty=0 it pops in that cycle, giving zero idle bit-times between frames beyond that one clock.
REQ-025 Changes to baud_div or the mode inputs mid-frame have no effect until the next pop.
REQ-026 busy=1 in every non-IDLE state and in the pop cycle; busy=0 otherwise.
REQ-027 Data-bit index counter width is clog2(DATA_WIDTH)+1; no wrap within a frame.

Reset
REQ-028 While rst=1: state=IDLE, txd=1, fifo_rd_en=0, busy=0, tx_done=0, all counters, shift register and latched configuration cleared.
REQ-029 rst asserted mid-frame aborts the frame: txd=1 on the next clk edge, the popped byte is discarded, and no tx_done is issued.
REQ-030 fifo_rd_en stays 0 during the reset cycle even if fifo_empty=0.

Structure
REQ-031 uart_pkg holds the tx state enumeration and default DATA_WIDTH/DIV_WIDTH constants, shared with the future uart_rx.
REQ-032 One sub-module, uart_baud_cnt (reloadable down-counter emitting a bit_end pulse), instantiated once; everything else is flat.

Verification
REQ-033 baud_div=4, 8N1, FIFO holds 0xA5 -> fifo_rd_en pulses once; txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; tx_done pulses at clock 40 after the pop; busy falls after it.
REQ-034 baud_div=3, parity_en=1, parity_odd=0, data 0x07 -> parity bit 1; parity_odd=1 -> parity bit 0; frame is 11 bits, 33 clocks.
REQ-035 stop2=1, baud_div=2, FIFO holds 0x55 then 0x00 -> second pop occurs exactly 1 clock after the first tx_done; each frame is 11 bits (22 clocks) with a 4-clock stop high.
REQ-036 baud_div=0 -> every bit lasts 1 clock; baud_div changed from 4 to 8 mid-frame -> current frame stays at 4, next frame at 8.
REQ-037 rst pulsed at clock 10 of a baud_div=4 frame -> txd=1, busy=0 next clock, no tx_done; after release with fifo_empty=0 a fresh frame starts with the FIFO's current head.
REQ-038 fifo_empty held 1 for 100 clocks -> fifo_rd_en never asserts, txd stays 1, busy stays 0.
